// File: rtl/imm_gen.sv
// Registered RV32I immediate generator with a main/skid two-entry buffer.
// Opcode is classified at acceptance; immediates are decoded from the held word.
module imm_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  imm_type,
    output logic [31:0] imm_J,
    output logic [31:0] imm_U,
    output logic [31:0] imm_B,
    output logic [31:0] imm_S,
    output logic [31:0] imm_I
);
    localparam int REG_LEN = 32;

    typedef enum logic [2:0] {
        IMM_J       = 3'b000,
        IMM_U       = 3'b001,
        IMM_B       = 3'b010,
        IMM_S       = 3'b011,
        IMM_I       = 3'b100,
        IMM_DEFAULT = 3'b101
    } imm_type_e;

    function automatic imm_type_e decode_type(input logic [6:0] opcode);
        case (opcode)
            7'b1101111:                         decode_type = IMM_J;
            7'b0110111, 7'b0010111:             decode_type = IMM_U;
            7'b1100011:                         decode_type = IMM_B;
            7'b0100011:                         decode_type = IMM_S;
            7'b0000011, 7'b0010011, 7'b1100111: decode_type = IMM_I;
            default:                            decode_type = IMM_DEFAULT;
        endcase
    endfunction

    // The opcode bits are consumed by the decode, so only bits [31:7] are kept.
    logic                   r_main_valid;
    logic [REG_LEN-1:7]     r_main_word;
    imm_type_e              r_main_type;
    logic                   r_skid_valid;
    logic [REG_LEN-1:7]     r_skid_word;
    imm_type_e              r_skid_type;

    logic      w_accept;
    logic      w_main_free;
    imm_type_e w_in_type;

    assign in_ready    = !r_skid_valid;
    assign w_accept    = in_valid && in_ready;
    assign w_main_free = !r_main_valid || out_ready;
    assign w_in_type   = decode_type(instr[6:0]);

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_word  <= '0;
            r_main_type  <= IMM_DEFAULT;
            r_skid_valid <= 1'b0;
            r_skid_word  <= '0;
            r_skid_type  <= IMM_DEFAULT;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_word  <= r_skid_word;
                r_main_type  <= r_skid_type;
                r_skid_valid <= w_accept;
                if (w_accept) begin
                    r_skid_word <= instr[REG_LEN-1:7];
                    r_skid_type <= w_in_type;
                end
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main_word <= instr[REG_LEN-1:7];
                    r_main_type <= w_in_type;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_word  <= instr[REG_LEN-1:7];
            r_skid_type  <= w_in_type;
        end
    end

    assign out_valid = r_main_valid;
    assign imm_type  = r_main_type;

    assign imm_I = {{20{r_main_word[31]}}, r_main_word[31:20]};
    assign imm_S = {{20{r_main_word[31]}}, r_main_word[31:25], r_main_word[11:7]};
    assign imm_B = {{19{r_main_word[31]}}, r_main_word[31], r_main_word[7],
                    r_main_word[30:25], r_main_word[11:8], 1'b0};
    assign imm_U = {r_main_word[31:12], 12'b0};
    assign imm_J = {{11{r_main_word[31]}}, r_main_word[31], r_main_word[19:12],
                    r_main_word[20], r_main_word[30:21], 1'b0};
endmodule

// File: tb/tb_imm_gen.sv
// Directed self-checking bench for imm_gen: reset, decode, streaming,
// back-pressure, flush and mid-stream reset.
module tb_imm_gen;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  imm_type;
    logic [31:0] imm_J, imm_U, imm_B, imm_S, imm_I;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] ADDI  = 32'hFFF00093;
    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] SW    = 32'h00112623;
    localparam logic [31:0] BEQ   = 32'hFE000EE3;
    localparam logic [31:0] JAL   = 32'h001000EF;
    localparam logic [31:0] LUI   = 32'h123452B7;

    typedef struct packed {
        logic [31:0] ins;
        logic [2:0]  ty;
        logic [2:0]  sel;
        logic [31:0] imm;
    } vec_t;

    vec_t stream [7];

    imm_gen dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_type  (imm_type),
        .imm_J     (imm_J),
        .imm_U     (imm_U),
        .imm_B     (imm_B),
        .imm_S     (imm_S),
        .imm_I     (imm_I)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_imm(input logic [2:0] sel);
        case (sel)
            3'd0:    pick_imm = imm_J;
            3'd1:    pick_imm = imm_U;
            3'd2:    pick_imm = imm_B;
            3'd3:    pick_imm = imm_S;
            default: pick_imm = imm_I;
        endcase
    endfunction

    initial begin
        stream[0] = '{SW,           3'b011, 3'd3, 32'h0000000C};
        stream[1] = '{BEQ,          3'b010, 3'd2, 32'hFFFFFFFC};
        stream[2] = '{JAL,          3'b000, 3'd0, 32'h00000800};
        stream[3] = '{LUI,          3'b001, 3'd1, 32'h12345000};
        stream[4] = '{32'h00000017, 3'b001, 3'd1, 32'h00000000};
        stream[5] = '{32'h00802003, 3'b100, 3'd4, 32'h00000008};
        stream[6] = '{32'hFFC000E7, 3'b100, 3'd4, 32'hFFFFFFFC};

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;

        // Asynchronous reset between edges
        #3 rst = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_imm_type",  {29'd0, imm_type},  32'd5);
        check("rst_imm_J", imm_J, 32'd0);
        check("rst_imm_U", imm_U, 32'd0);
        check("rst_imm_B", imm_B, 32'd0);
        check("rst_imm_S", imm_S, 32'd0);
        check("rst_imm_I", imm_I, 32'd0);
        tick(); tick();
        rst = 1'b0;

        // I-type then R-type
        out_ready = 1'b1; in_valid = 1'b1; instr = ADDI;
        tick();
        instr = ADD;
        check("addi_valid", {31'd0, out_valid}, 32'd1);
        check("addi_type",  {29'd0, imm_type},  32'd4);
        check("addi_imm_I", imm_I, 32'hFFFFFFFF);
        check("addi_imm_S", imm_S, 32'hFFFFFFE1);
        check("addi_imm_U", imm_U, 32'hFFF00000);
        tick();
        in_valid = 1'b0;
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_type",  {29'd0, imm_type},  32'd5);
        tick();
        check("idle_valid", {31'd0, out_valid}, 32'd0);

        // Back-to-back stream, one result per cycle
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            instr    = stream[i].ins;
            tick();
            check($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stream%0d_ready", i), {31'd0, in_ready},  32'd1);
            check($sformatf("stream%0d_type", i),  {29'd0, imm_type},  {29'd0, stream[i].ty});
            check($sformatf("stream%0d_imm", i),   pick_imm(stream[i].sel), stream[i].imm);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", {31'd0, out_valid}, 32'd0);

        // Back-pressure: SW in main, BEQ in skid, JAL held at input
        out_ready = 1'b0; in_valid = 1'b1; instr = SW;
        tick();
        check("bp_sw_type",  {29'd0, imm_type}, 32'd3);
        check("bp_sw_ready", {31'd0, in_ready}, 32'd1);
        instr = BEQ;
        tick();
        check("bp_skid_ready", {31'd0, in_ready}, 32'd0);
        instr = JAL;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("bp_hold%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_hold%0d_type", i),  {29'd0, imm_type},  32'd3);
            check($sformatf("bp_hold%0d_imm_S", i), imm_S, 32'h0000000C);
            check($sformatf("bp_hold%0d_ready", i), {31'd0, in_ready},  32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("rel_beq_type",  {29'd0, imm_type}, 32'd2);
        check("rel_beq_imm_B", imm_B, 32'hFFFFFFFC);
        check("rel_ready",     {31'd0, in_ready}, 32'd1);
        tick();
        check("rel_jal_type",  {29'd0, imm_type}, 32'd0);
        check("rel_jal_imm_J", imm_J, 32'h00000800);
        instr = LUI;
        tick();
        check("rel_lui_type",  {29'd0, imm_type}, 32'd1);
        check("rel_lui_imm_U", imm_U, 32'h12345000);
        in_valid = 1'b0;
        tick();
        check("rel_end_valid", {31'd0, out_valid}, 32'd0);

        // Flush with both entries full
        out_ready = 1'b0; in_valid = 1'b1; instr = SW;
        tick();
        instr = BEQ;
        tick();
        check("fl_full_ready", {31'd0, in_ready}, 32'd0);
        instr = LUI; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_ready", {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
        tick();
        check("fl_no_ghost", {31'd0, out_valid}, 32'd0);
        // Word offered with in_ready=1 in the flush cycle is dropped
        in_valid = 1'b1; instr = JAL; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_drop_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; instr = SW;
        tick();
        instr = BEQ;
        tick();
        instr = JAL;
        #2 rst = 1'b1;
        #1;
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_ready", {31'd0, in_ready},  32'd1);
        check("mrst_type",  {29'd0, imm_type},  32'd5);
        check("mrst_imm_B", imm_B, 32'd0);
        tick();
        check("mrst_hold_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b1; instr = LUI; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mrst_first_valid", {31'd0, out_valid}, 32'd1);
        check("mrst_first_type",  {29'd0, imm_type},  32'd1);
        check("mrst_first_imm_U", imm_U, 32'h12345000);
        tick();
        check("mrst_end_valid", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/imm_gen.md
# imm_gen

Registered immediate-generation stage for the RV32I core. Accepts one 32-bit instruction word per cycle over a valid/ready handshake, classifies its opcode into the 3-bit immediate-type code, and produces all five sign-extended immediates (J, U, B, S, I). Its outputs feed the core's immediate multiplexer directly. A two-entry buffer (output register plus skid register) gives full throughput under back-pressure.

## Interface
- No parameters. All data widths are `REG_LEN` (32) from `rysy_pkg.vh`.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous clear of both buffer entries.
- `in_valid` input 1: `instr` is valid.
- `in_ready` output 1: the stage accepts `instr` this cycle.
- `instr` input 32: instruction word.
- `out_valid` output 1: output fields are valid.
- `out_ready` input 1: downstream consumes the output this cycle.
- `imm_type` output 3: J=000, U=001, B=010, S=011, I=100, DEFAULT=101.
- `imm_J`, `imm_U`, `imm_B`, `imm_S`, `imm_I` output 32 each: immediates of the held instruction.

## Operation
- Opcode is `instr[6:0]`. It maps to `imm_type` as follows:
  - 1101111 → J
  - 0110111 and 0010111 → U
  - 1100011 → B
  - 0100011 → S
  - 0000011, 0010011 and 1100111 → I
  - everything else → DEFAULT
- `imm_type` is decoded at acceptance and stored with the word.
- The immediates are pure functions of the stored word `w`, and all five are always driven regardless of `imm_type`:
  - I = {{20{w[31]}}, w[31:20]}
  - S = {{20{w[31]}}, w[31:25], w[11:7]}
  - B = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}
  - U = {w[31:12], 12'b0}
  - J = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}
- Storage is two entries:
  - `main` drives the outputs; `out_valid` = main valid.
  - `skid` holds one overflow entry.
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- `in_ready` = !skid valid, combinational from the flop.
- Per-edge update (flush excluded):
  - Main empty or draining, skid full: skid moves to main. An accepted input goes to skid.
  - Main empty or draining, skid empty: an accepted input goes to main.
  - Main holding (valid and not draining): an accepted input goes to skid.
- Order is strictly first-in first-out. No entry is dropped or duplicated.
- `flush` clears main and skid valids and takes priority over everything. An input presented in the flush cycle is discarded, even if `in_ready` was 1.

## Timing
- Latency is 1 cycle. A word accepted at edge N gives `out_valid`=1 with its fields after edge N.
- Throughput is 1 word/cycle while `out_ready`=1.
- While `out_valid && !out_ready`, all outputs hold stable.
- `in_ready` falls the cycle after the skid fills. It rises the cycle after the skid empties.
- Reset (asynchronous, immediate, without a clock edge):
  - `out_valid`=0, skid empty, `in_ready`=1.
  - Stored word = 0, so all immediates = 0.
  - `imm_type`=101.
- While `rst` is high, inputs are ignored.
- A reset asserted mid-stream drops both entries.
- Flush with `rst` high: reset dominates.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → immediately `out_valid`=0, `in_ready`=1, `imm_type`=101, all immediates 0x00000000.
- **I-type and R-type:**
  - ADDI 0xFFF00093 with `out_ready`=1 → after one edge `out_valid`=1, `imm_type`=100, `imm_I`=0xFFFFFFFF.
  - Then ADD 0x002081B3 → `imm_type`=101.
- **Back-to-back stream with `out_ready`=1:**
  - SW 0x00112623 → type 011, `imm_S`=0x0000000C.
  - BEQ 0xFE000EE3 → type 010, `imm_B`=0xFFFFFFFC.
  - JAL 0x001000EF → type 000, `imm_J`=0x00000800.
  - LUI 0x123452B7 → type 001, `imm_U`=0x12345000.
  - Expect one result per cycle, no bubbles.
- **Back-pressure:**
  - Hold `out_ready`=0 and offer the four words above continuously → SW held in main, BEQ in skid, `in_ready`=0 from the next cycle, JAL held at input.
  - Release `out_ready` → outputs SW, BEQ, JAL, LUI on consecutive cycles.
- **Flush:** with both entries full and `in_valid`=1, pulse `flush` → next cycle `out_valid`=0, `in_ready`=1. The offered word never appears at the output.
- **Reset mid-stream:** with both entries full, assert `rst` → `out_valid` falls without a clock edge. After release, the next accepted word is the first one output.
